conv_feed_seq: RTL

//  Upstream feeder for Conv_acc. Accepts a valid/ready word stream from the DMA side, buffers it in a small FIFO, and drives

---
 rtl/conv_acc_pkg.sv | 15 +
 rtl/conv_feed_seq_if.sv | 11 +
 rtl/conv_feed_fifo.sv | 55 +++++
 rtl/conv_feed_seq.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/conv_acc_pkg.sv
// Shared constants and state encoding for the Conv_acc feed/accumulate path.
package conv_acc_pkg;

  localparam int DATA_W = 64;
  localparam int KSIZE  = 9;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_W     = 3'd1,
    WAIT_IMG   = 3'd2,
    STREAM_IMG = 3'd3,
    DONE       = 3'd4
  } feed_state_e;

endpackage

// File: rtl/conv_feed_seq_if.sv
// Valid/ready word stream from the DMA side into the feeder.
interface conv_feed_seq_if #(
  parameter int DATA_W = conv_acc_pkg::DATA_W
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/conv_feed_fifo.sv
// First-word-fall-through FIFO; dout always shows the oldest stored word.
// Push when full and pop when empty are silently dropped.
module conv_feed_fifo #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            push,
  input  logic                            pop,
  input  logic [DATA_W-1:0]               din,
  output logic [DATA_W-1:0]               dout,
  output logic [$clog2(FIFO_DEPTH):0]     count,
  output logic                            full,
  output logic                            empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents are don't-care until pointers say otherwise.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/conv_feed_seq.sv
// Feeder for Conv_acc: buffers the DMA word stream and replays it as one
// weight burst followed by N image bursts, each burst on consecutive cycles.
module conv_feed_seq import conv_acc_pkg::*; #(
  parameter int FIFO_DEPTH = 16,
  parameter int WIN_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [WIN_W-1:0]  i_num_windows,
  conv_feed_seq_if.slave    s,
  output logic [DATA_W-1:0] o_Data,
  output logic              o_Data_valid,
  output logic              o_Weight_setup,
  output logic              o_busy,
  output logic              o_done
);

  localparam int ACC_W = WIN_W + 4;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TAP_W = $clog2(KSIZE);

  feed_state_e       state;
  feed_state_e       next_state;
  logic [WIN_W-1:0]  n_reg;
  logic [WIN_W-1:0]  win_cnt;
  logic [WIN_W:0]    win_next;
  logic [TAP_W-1:0]  tap_cnt;
  logic [ACC_W-1:0]  acc_cnt;
  logic [ACC_W-1:0]  job_total;
  logic [DATA_W-1:0] fifo_dout;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              burst_ready;
  logic              last_tap;
  logic              last_win;
  logic [DATA_W-1:0] data_nxt;
  logic              valid_nxt;
  logic              setup_nxt;

  assign burst_ready = (fifo_count >= CNT_W'(KSIZE));
  assign last_tap    = (tap_cnt == TAP_W'(KSIZE - 1));
  assign win_next    = {1'b0, win_cnt} + (WIN_W+1)'(1);
  assign last_win    = (win_next == {1'b0, n_reg});
  assign job_total   = ACC_W'(KSIZE) * (ACC_W'(n_reg) + ACC_W'(1));

  assign s.ready = (state != IDLE) & ~fifo_full & (acc_cnt < job_total);
  assign push    = s.valid & s.ready;

  // A burst only begins with a full kernel buffered, so once tap 0 is popped
  // the remaining taps are guaranteed to be present.
  always_comb begin
    pop = 1'b0;
    case (state)
      LOAD_W:     pop = ((tap_cnt != '0) | burst_ready) & ~fifo_empty;
      STREAM_IMG: pop = ~fifo_empty;
      default:    pop = 1'b0;
    endcase
  end

  conv_feed_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (s.data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Sequencing of weight load, image bursts and the completion pulse.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (i_start) next_state = LOAD_W;
      LOAD_W:     if (pop && last_tap) next_state = (n_reg == '0) ? DONE : WAIT_IMG;
      WAIT_IMG:   if (burst_ready) next_state = STREAM_IMG;
      STREAM_IMG: if (last_tap) next_state = last_win ? DONE : WAIT_IMG;
      DONE:       next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  // Job length latch plus tap, window and accepted-word counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_reg   <= '0;
      win_cnt <= '0;
      tap_cnt <= '0;
      acc_cnt <= '0;
    end else if (state == IDLE && i_start) begin
      n_reg   <= i_num_windows;
      win_cnt <= '0;
      tap_cnt <= '0;
      acc_cnt <= '0;
    end else begin
      if (push) acc_cnt <= acc_cnt + ACC_W'(1);
      if (pop)  tap_cnt <= last_tap ? '0 : tap_cnt + TAP_W'(1);
      if (state == STREAM_IMG && last_tap) win_cnt <= win_next[WIN_W-1:0];
    end
  end

  // Next values for the Conv_acc-facing outputs; setup stays high until the
  // first image word and falls together with it.
  always_comb begin
    data_nxt  = '0;
    valid_nxt = 1'b0;
    setup_nxt = 1'b1;
    case (state)
      LOAD_W: begin
        if (pop) begin
          data_nxt  = fifo_dout;
          valid_nxt = 1'b1;
        end
      end
      WAIT_IMG:   setup_nxt = (win_cnt == '0);
      STREAM_IMG: begin
        data_nxt  = fifo_dout;
        valid_nxt = 1'b1;
        setup_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  // Output register stage; everything lags the FSM by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_Data         <= '0;
      o_Data_valid   <= 1'b0;
      o_Weight_setup <= 1'b1;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
    end else begin
      o_Data         <= data_nxt;
      o_Data_valid   <= valid_nxt;
      o_Weight_setup <= setup_nxt;
      o_busy         <= (state != IDLE);
      o_done         <= (state == DONE);
    end
  end

endmodule
